// File: rtl/skolem_sweep_checker.sv
// Exhaustive Skolem-function checker: sweeps all 2^N_IN input vectors and counts formula failures.
// Optional build macro SKOLEM_SWEEP_HALT_ON_FAIL_EN ends the sweep on the first failing vector.
module skolem_sweep_checker #(
   parameter int N_IN = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] vec_out,
   input  logic            skolem_in,
   input  logic            spec_ok,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   fail_cnt,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [N_IN-1:0] VEC_MAX = '1;
   localparam logic [N_IN:0]   CNT_MAX = {1'b1, {N_IN{1'b0}}};

   state_t state;
   logic   fail;
   logic   last;
   logic   stop;

   // The Skolem output is judged only through the external spec_ok evaluation.
   logic unused_skolem;
   assign unused_skolem = skolem_in;

   always_comb begin
      fail = ~spec_ok;
      last = (vec_out == VEC_MAX);
`ifdef SKOLEM_SWEEP_HALT_ON_FAIL_EN
      stop = last | fail;
`else
      stop = last;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         vec_out          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         fail_cnt         <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state            <= RUN;
                  vec_out          <= '0;
                  fail_cnt         <= '0;
                  first_fail_vec   <= '0;
                  first_fail_valid <= 1'b0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
               end
            end
            RUN: begin
               if (fail) begin
                  if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + (N_IN+1)'(1);
                  if (!first_fail_valid) begin
                     first_fail_vec   <= vec_out;
                     first_fail_valid <= 1'b1;
                  end
               end
               // pass folds in the failure sampled on this same closing edge.
               if (stop) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_cnt == '0) && !fail;
               end else begin
                  vec_out <= vec_out + N_IN'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule
